// File: rtl/alu_operand_issue.sv
// alu_operand_issue: register file plus issue stage feeding a 32-bit ALU
// with one registered cycle of latency.
//
// An accepted op reads both operands, holds them for the ALU through EXEC,
// writes the ALU result back in WB and latches the ALU status flags.
//
// Optional build macro ALU_ISSUE_FWD_EN:
//   - Accepts a new op during WB, for one op every 2 cycles.
//   - Forwards alu_result to a source that matches the completing rd.
// When the macro is not defined, an op is accepted only in IDLE
// (one op every 3 cycles).
module alu_operand_issue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [ADDR_W-1:0] op_rs,
    input  logic [ADDR_W-1:0] op_rt,
    input  logic [ADDR_W-1:0] op_rd,
    input  logic [3:0]        op_ctrl,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    output logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_cout,
    input  logic              alu_ovf,
    output logic              wb_done,
    output logic              flag_zero,
    output logic              flag_cout,
    output logic              flag_ovf,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t                       state;
    logic [NREG-1:0][DATA_W-1:0]  regs;
    logic [ADDR_W-1:0]            rd_q;
    logic [DATA_W-1:0]            rs_val;
    logic [DATA_W-1:0]            rt_val;
    logic                         accept;

    assign wb_done  = (state == WB);
    assign accept   = op_valid && op_ready;
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

`ifdef ALU_ISSUE_FWD_EN
    assign op_ready = (state == IDLE) || (state == WB);

    // Operand read. While the previous op is still in WB, its result is not
    // yet in the register file, so a matching source takes alu_result instead.
    always_comb begin
        rs_val = (op_rs == '0) ? '0 : regs[op_rs];
        rt_val = (op_rt == '0) ? '0 : regs[op_rt];
        if (state == WB && rd_q != '0) begin
            if (op_rs == rd_q) rs_val = alu_result;
            if (op_rt == rd_q) rt_val = alu_result;
        end
    end
`else
    assign op_ready = (state == IDLE);

    // Operand read straight from the register file. r0 always reads as zero.
    always_comb begin
        rs_val = (op_rs == '0) ? '0 : regs[op_rs];
        rt_val = (op_rt == '0) ? '0 : regs[op_rt];
    end
`endif

    // Issue FSM, ALU operand registers, register-file write-back and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            regs      <= '0;
            rd_q      <= '0;
            alu_src1  <= '0;
            alu_src2  <= '0;
            alu_ctrl  <= '0;
            flag_zero <= 1'b0;
            flag_cout <= 1'b0;
            flag_ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_src1 <= rs_val;
                        alu_src2 <= rt_val;
                        alu_ctrl <= op_ctrl;
                        rd_q     <= op_rd;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    // The ALU samples the held operands at the end of this cycle.
                    state <= WB;
                end
                WB: begin
                    if (rd_q != '0) regs[rd_q] <= alu_result;
                    flag_zero <= alu_zero;
                    flag_cout <= alu_cout;
                    flag_ovf  <= alu_ovf;
                    // accept is only ever true here when forwarding is built in.
                    if (accept) begin
                        alu_src1 <= rs_val;
                        alu_src2 <= rt_val;
                        alu_ctrl <= op_ctrl;
                        rd_q     <= op_rd;
                        state    <= EXEC;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
